tc0260dar_palette: RTL
======================

// Module: tc0260dar_palette
// PURPOSE
//  Palette stage directly downstream of the tilemap generator. Takes the 15-bit SC colour index per pixel,
//  looks it up in internal single-port palette RAM and drives 8-bit RGB plus delayed blanking to the video out.
//  Exposes a 68000-style CPU window (byte lanes, DTACK) for palette read/write.
//  Time-multiplexes CPU and video on the one RAM port.
// PARAMETERS
//  PAL_AW   12  palette address width (entries = 2**PAL_AW); SC[PAL_AW-1:0] used, upper SC bits ignored
//  FORMAT   0   0 = xBGR555 {x,B[14:10],G[9:5],R[4:0]}; 1 = RGBx444 {R[15:12],G[11:8],B[7:4],x}
// PORTS
//  clk      in   1       system clock
//  reset_n  in   1       asynchronous, active-low reset
//  ce_13m   in   1       13 MHz clock enable
//  ce_pixel in   1       pixel enable (subset of ce_13m cycles, every 2nd)
//  VA       in   PAL_AW  CPU word address (VA[PAL_AW:1])
//  Din      in   16      CPU write data
//  Dout     out  16      CPU read data
//  UDSn     in   1       upper byte strobe
//  LDSn     in   1       lower byte strobe
//  RW       in   1       1 = read, 0 = write
//  PALCSn   in   1       palette chip select
//  DACKn    out  1       data acknowledge, active low
//  SC       in   15      colour index from tilemap stage
//  HBLOn    in   1       h-blank in, active low
//  VBLOn    in   1       v-blank in, active low
//  R,G,B    out  8 each  colour out
//  HBLn     out  1       h-blank aligned to RGB
//  VBLn     out  1       v-blank aligned to RGB
// BEHAVIOUR
//  Reset (async assert, sync release): R=G=B=0, HBLn=VBLn=0, Dout=0, DACKn=1, pending=0. RAM contents undefined.
//  RAM slots: ce_13m&ce_pixel = VIDEO slot; ce_13m&~ce_pixel = CPU slot. No other cycle touches RAM.
//  Video pipe, 1 ce_pixel latency:
//   VIDEO slot N: RAM addr = SC[PAL_AW-1:0]; HBLOn/VBLOn sampled.
//   VIDEO slot N+1: RGB and HBLn/VBLn register the result.
//   If HBLOn&VBLOn == 0 in the sampled pixel: RGB = 0.
//  Expansion to 8 bits is MSB replication:
//   5-bit c -> {c,c[4:2]}
//   4-bit c -> {c,c}
//  CPU FSM, advances on ce_13m only:
//   IDLE: prev_cs registered. Falling edge of PALCSn -> latch VA/Din/UDSn/LDSn/RW -> PEND.
//   PEND: at next CPU slot, perform the access:
//    - write: byte lanes gated by ~UDSn/~LDSn
//    - read: Dout <= RAM word
//    Then DACKn=0 -> ACK.
//   ACK: hold DACKn=0 until PALCSn=1, then DACKn=1 -> IDLE.
//   PALCSn rising while in PEND: cancel, no RAM write, DACKn stays 1 -> IDLE.
//  DACKn is forced to 1 whenever PALCSn=1, combinationally.
//  Read access: from CS edge to DACKn low takes 1..3 ce_13m cycles.
//  Write then video read of the same entry: the video read sees the new value from the next VIDEO slot on.
//  No CPU-slot starvation: every pixel period has exactly one CPU slot.
//  Reset during PEND/ACK: access is discarded and no partial write occurs.
// TESTING
//  1. Reset: hold reset_n=0 with clocks running -> RGB=0, DACKn=1, HBLn=VBLn=0. Release -> unchanged until first VIDEO slot.
//  2. FORMAT=0, CPU writes 0x7C1F to entry 0x005 (UDS+LDS); SC=0x005 with blanks high.
//     Expect R=0xFF, G=0x00, B=0xFF exactly 1 ce_pixel later. DACKn goes low within 3 ce_13m cycles of CS fall.
//  3. Byte lanes: write 0x1234 to 0x010, then write 0xAB00 with LDSn=1. Read back 0x010 -> Dout=0xAB34, DACKn low.
//  4. Blanking: SC=0x005 (nonzero colour), HBLOn=0 for 8 pixels.
//     Expect RGB=0 and HBLn=0 for the same 8 pixels, shifted by 1 pixel.
//  5. Cancel: PALCSn low for 1 ce_13m cycle, raised before a CPU slot, Din=0xFFFF to 0x020 -> 0x020 is unchanged.
//     DACKn never goes low.
//  6. FORMAT=1: write 0xF0A0 to entry 0x001, SC=0x801 with PAL_AW=11 -> R=0xFF, G=0x00, B=0xAA (SC upper bits ignored).

Source files
------------

// File: rtl/tc0260dar_palette.sv
// Palette lookup: 15-bit SC index -> 8-bit RGB via single-port RAM shared between the video pipe
// (ce_pixel slots, 1-pixel latency) and a 68000-style CPU window that holds DTACK until its slot.
module tc0260dar_palette #(
  parameter int PAL_AW = 12,
  parameter bit FORMAT = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_13m,
  input  logic              ce_pixel,
  input  logic [PAL_AW:1]   VA,
  input  logic [15:0]       Din,
  output logic [15:0]       Dout,
  input  logic              UDSn,
  input  logic              LDSn,
  input  logic              RW,
  input  logic              PALCSn,
  output logic              DACKn,
  input  logic [14:0]       SC,
  input  logic              HBLOn,
  input  logic              VBLOn,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              HBLn,
  output logic              VBLn
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACK} state_t;

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  state_t            r_state, w_state_nxt;
  logic              r_prev_cs;
  logic [PAL_AW-1:0] r_addr;
  logic [15:0]       r_din;
  logic [1:0]        r_be;
  logic              r_rw;
  logic [15:0]       r_mem [1<<PAL_AW];
  logic [15:0]       r_vid_dat;
  logic              r_hbl_s, r_vbl_s;
  logic              w_vid_slot, w_cpu_slot, w_fall, w_acc;
  logic [7:0]        w_r, w_g, w_b;
  logic              w_unused_sc;

  function automatic logic [7:0] x5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] x4(input logic [3:0] c);
    return {c, c};
  endfunction

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_vid_slot  = ce_13m & ce_pixel;
  assign w_cpu_slot  = ce_13m & ~ce_pixel;
  assign w_fall      = ce_13m & r_prev_cs & ~PALCSn;
  assign w_acc       = (r_state == S_PEND) & w_cpu_slot & ~PALCSn;
  assign DACKn       = (r_state != S_ACK) | PALCSn;
  assign w_unused_sc = ^{SC, r_vid_dat};

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_fall) w_state_nxt = S_PEND;
      S_PEND: begin
        if (ce_13m && PALCSn) w_state_nxt = S_IDLE;
        else if (w_acc)       w_state_nxt = S_ACK;
      end
      S_ACK:  if (ce_13m && PALCSn) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_prev_cs <= 1'b1;
      r_addr    <= '0;
      r_din     <= '0;
      r_be      <= '0;
      r_rw      <= 1'b1;
      Dout      <= '0;
    end else begin
      if (ce_13m) r_prev_cs <= PALCSn;
      if (r_state == S_IDLE && w_fall) begin
        r_addr <= VA;
        r_din  <= Din;
        r_be   <= {~UDSn, ~LDSn};
        r_rw   <= RW;
      end
      if (w_acc && r_rw) Dout <= r_mem[r_addr];
    end
  end

  // One port: video owns the address in pixel slots, the CPU in the others.
  always_ff @(posedge clk) begin
    if (w_acc && !r_rw) begin
      if (r_be[1]) r_mem[r_addr][15:8] <= r_din[15:8];
      if (r_be[0]) r_mem[r_addr][7:0]  <= r_din[7:0];
    end
    if (w_vid_slot) r_vid_dat <= r_mem[SC[PAL_AW-1:0]];
  end

  always_comb begin
    if (FORMAT == 1'b0) begin
      w_r = x5(r_vid_dat[4:0]);
      w_g = x5(r_vid_dat[9:5]);
      w_b = x5(r_vid_dat[14:10]);
    end else begin
      w_r = x4(r_vid_dat[15:12]);
      w_g = x4(r_vid_dat[11:8]);
      w_b = x4(r_vid_dat[7:4]);
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hbl_s <= 1'b0;
      r_vbl_s <= 1'b0;
      HBLn    <= 1'b0;
      VBLn    <= 1'b0;
      R       <= '0;
      G       <= '0;
      B       <= '0;
    end else if (w_vid_slot) begin
      r_hbl_s <= HBLOn;
      r_vbl_s <= VBLOn;
      HBLn    <= r_hbl_s;
      VBLn    <= r_vbl_s;
      R       <= (r_hbl_s & r_vbl_s) ? w_r : 8'h00;
      G       <= (r_hbl_s & r_vbl_s) ? w_g : 8'h00;
      B       <= (r_hbl_s & r_vbl_s) ? w_b : 8'h00;
    end
  end

endmodule
